// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch FIFO entry type for the instruction fetch slice.
package fetch_pkg;

    localparam int         DEF_ADDR_W  = 8;
    localparam logic [7:0] DEF_NOP_OPC = 8'h00;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [7:0]            opc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: program-memory read port, decode-side byte stream and redirect input.
interface fetch_unit_if #(
    parameter int ADDR_W = fetch_pkg::DEF_ADDR_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              stall_en;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic [7:0]        opcode;
    logic              opcode_valid;
    logic [ADDR_W-1:0] opcode_pc;

    modport master (
        output mem_req, mem_addr, opcode, opcode_valid, opcode_pc,
        input  mem_data, stall_en, redirect_en, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, opcode, opcode_valid, opcode_pc,
        output mem_data, stall_en, redirect_en, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; flush beats push and pop, head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic   clk,
    input  logic   srst,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    input  logic   flush,
    output logic [PW:0] count,
    output entry_t head
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Sequential byte fetcher: issues program-memory reads, queues responses and streams them to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int         ADDR_W  = DEF_ADDR_W,
    parameter int         DEPTH   = 4,
    parameter logic [7:0] NOP_OPC = DEF_NOP_OPC
) (
    input logic          clk,
    input logic          sync_rst,
    fetch_unit_if.master bus
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [7:0]        opc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] req_pc_reg;
    logic              inflight_reg;
    logic              discard_reg;

    logic [PW:0]   count;
    entry_t        head;
    entry_t        push_data;
    logic          valid;
    logic          consume;
    logic          push;
    logic [PW+1:0] occupancy;

    assign valid     = (count != '0);
    assign consume   = valid & ~bus.stall_en & ~bus.redirect_en;
    // Slots already owed to outstanding reads count as used, so a response always has room.
    assign occupancy = {1'b0, count} + (PW+2)'(inflight_reg) - (PW+2)'(consume);
    assign bus.mem_req  = ~bus.redirect_en & (occupancy < (PW+2)'(DEPTH));
    assign bus.mem_addr = fetch_pc_reg;

    assign push      = inflight_reg & ~discard_reg;
    assign push_data = '{pc: req_pc_reg, opc: bus.mem_data};

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            fetch_pc_reg <= '0;
            req_pc_reg   <= '0;
            inflight_reg <= 1'b0;
            discard_reg  <= 1'b0;
        end else begin
            inflight_reg <= bus.mem_req;
            discard_reg  <= bus.redirect_en;
            if (bus.mem_req) begin
                req_pc_reg <= fetch_pc_reg;
            end
            if (bus.redirect_en) begin
                fetch_pc_reg <= bus.redirect_pc;
            end else if (bus.mem_req) begin
                fetch_pc_reg <= fetch_pc_reg + ADDR_W'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .srst      (sync_rst),
        .push      (push),
        .push_data (push_data),
        .pop       (consume),
        .flush     (bus.redirect_en),
        .count     (count),
        .head      (head)
    );

    assign bus.opcode_valid = valid;
    assign bus.opcode       = valid ? head.opc : NOP_OPC;
    assign bus.opcode_pc    = valid ? head.pc  : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns its own address, so each byte must equal its pc.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic sync_rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit_if #(.ADDR_W(8)) bus ();

    fetch_unit #(
        .ADDR_W  (8),
        .DEPTH   (4),
        .NOP_OPC (8'h00)
    ) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .bus      (bus)
    );

    // Program memory model: one-cycle read latency, data equals address.
    always @(posedge clk) bus.mem_data <= bus.mem_req ? bus.mem_addr : 8'hEE;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // FIFO must never be pushed while full or popped while empty.
    always @(posedge clk) begin
        if (sync_rst === 1'b0) begin
            check_eq("overflow", 32'(dut.u_fifo.push & ~dut.u_fifo.pop & ~dut.u_fifo.flush
                                    & (dut.u_fifo.count == 3'd4)), 32'd0);
            check_eq("underflow", 32'(dut.u_fifo.pop & (dut.u_fifo.count == 3'd0)), 32'd0);
        end
    end

    task automatic drive(input bit rst, input bit st, input bit rd, input logic [7:0] rpc);
        @(negedge clk);
        sync_rst        = rst;
        bus.stall_en    = st;
        bus.redirect_en = rd;
        bus.redirect_pc = rpc;
        #1;
    endtask

    task automatic expect_out(input string tag, input bit v, input logic [7:0] opc);
        $display("cyc %0d %s: valid=%0b opcode=%02h pc=%02h req=%0b addr=%02h", cyc, tag,
                 bus.opcode_valid, bus.opcode, bus.opcode_pc, bus.mem_req, bus.mem_addr);
        check_eq($sformatf("%s.valid", tag), 32'(bus.opcode_valid), 32'(v));
        check_eq($sformatf("%s.opcode", tag), 32'(bus.opcode), 32'(opc));
        check_eq($sformatf("%s.pc", tag), 32'(bus.opcode_pc), v ? 32'(opc) : 32'd0);
    endtask

    task automatic expect_req(input string tag, input bit req, input logic [7:0] addr);
        check_eq($sformatf("%s.req", tag), 32'(bus.mem_req), 32'(req));
        if (req) check_eq($sformatf("%s.addr", tag), 32'(bus.mem_addr), 32'(addr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall_en    = 1'b0;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (3) @(posedge clk);

        // Reset state and release latency
        drive(1, 0, 0, 8'h00); expect_out("rst", 0, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rel0", 0, 8'h00); expect_req("rel0", 1, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rel1", 0, 8'h00); expect_req("rel1", 1, 8'h01);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 8'h00); expect_out("seq", 1, 8'(k));
        end

        // Stall for 6 cycles with 03 at the head
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 8'h00); expect_out("stall", 1, 8'h03);
            expect_req("stall", i < 2, 8'(5 + i));
        end
        for (int k = 3; k < 8; k++) begin
            drive(0, 0, 0, 8'h00); expect_out("unstall", 1, 8'(k));
            if (k == 3) expect_req("unstall", 1, 8'h07);
        end

        // Redirect to 0x40 with 3 queued and 1 in flight
        drive(0, 0, 1, 8'h40); expect_out("rd40.T", 1, 8'h08); expect_req("rd40.T", 0, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rd40.T1", 0, 8'h00); expect_req("rd40.T1", 1, 8'h40);
        drive(0, 0, 0, 8'h00); expect_out("rd40.T2", 0, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rd40.T3", 1, 8'h40);
        drive(0, 0, 0, 8'h00); expect_out("rd40.T4", 1, 8'h41);

        // Redirect to 0xFE, address wraps
        drive(0, 0, 1, 8'hFE); expect_out("rdfe.T", 1, 8'h42);
        drive(0, 0, 0, 8'h00); expect_out("rdfe.T1", 0, 8'h00); expect_req("rdfe.T1", 1, 8'hFE);
        drive(0, 0, 0, 8'h00); expect_out("rdfe.T2", 0, 8'h00); expect_req("rdfe.T2", 1, 8'hFF);
        drive(0, 0, 0, 8'h00); expect_out("rdfe.T3", 1, 8'hFE); expect_req("rdfe.T3", 1, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rdfe.T4", 1, 8'hFF);
        drive(0, 0, 0, 8'h00); expect_out("rdfe.T5", 1, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rdfe.T6", 1, 8'h01);

        // Fill the FIFO under stall, then redirect and stall together
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 8'h00); expect_out("fill", 1, 8'h02);
        end
        drive(0, 1, 1, 8'h80); expect_out("rd80.T", 1, 8'h02); expect_req("rd80.T", 0, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rd80.T1", 0, 8'h00); expect_req("rd80.T1", 1, 8'h80);
        drive(0, 0, 0, 8'h00); expect_out("rd80.T2", 0, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("rd80.T3", 1, 8'h80);
        drive(0, 0, 0, 8'h00); expect_out("rd80.T4", 1, 8'h81);
        drive(0, 0, 0, 8'h00); expect_out("rd80.T5", 1, 8'h82);

        // Mid-stream reset with a response in flight
        drive(1, 0, 0, 8'h00); expect_out("mrst.T", 1, 8'h83);
        drive(0, 0, 0, 8'h00); expect_out("mrst.T1", 0, 8'h00); expect_req("mrst.T1", 1, 8'h00);
        drive(0, 0, 0, 8'h00); expect_out("mrst.T2", 0, 8'h00); expect_req("mrst.T2", 1, 8'h01);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 8'h00); expect_out("mrst.seq", 1, 8'(k));
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
